// File: rtl/adc_spi_master.sv
// adc_spi_master: SPI master for a 12-bit serial ADC; one 16-SCLK frame per start request.
// The channel address goes out on bits 2..4 and bits 4..15 are captured as the result.
module adc_spi_master #(
    parameter int unsigned HALF_DIV = 25
) (
    input  logic        CLK50MHZ,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  chan,
    output logic        busy,
    output logic        sample_valid,
    output logic [11:0] sample_data,
    output logic [2:0]  sample_chan,
    output logic        ADC_CS_N,
    output logic        ADC_SCLK,
    output logic        ADC_SADDR,
    input  logic        ADC_SDAT
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, HOLD} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  k_q;
    logic [2:0]  chan_q;
    logic [11:0] shreg_q;
    logic        armed_q;
    logic        busy_q, valid_q, cs_n_q, sclk_q, saddr_q;
    logic [11:0] data_q;
    logic [2:0]  schan_q;
    logic        cnt_last;
    logic [7:0]  cnt_d;

    assign cnt_last = cnt_q == 8'(HALF_DIV - 1);
    assign cnt_d    = cnt_last ? 8'd0 : cnt_q + 8'd1;

    function automatic logic addr_bit(input logic [3:0] k, input logic [2:0] c);
        return k == 4'd2 ? c[2] : k == 4'd3 ? c[1] : k == 4'd4 ? c[0] : 1'b0;
    endfunction

    always_ff @(posedge CLK50MHZ) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            chan_q  <= '0;
            shreg_q <= '0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            saddr_q <= 1'b0;
            data_q  <= '0;
            schan_q <= '0;
        end else begin
            // armed_q keeps start from being taken on the first edge after reset
            armed_q <= 1'b1;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start && armed_q) begin
                    state_q <= SETUP;
                    chan_q  <= chan;
                    busy_q  <= 1'b1;
                    cs_n_q  <= 1'b0;
                    cnt_q   <= '0;
                    shreg_q <= '0;
                end
                SETUP: begin
                    cnt_q <= cnt_d;
                    if (cnt_last) begin
                        state_q <= SHIFT;
                        sclk_q  <= 1'b0;
                        k_q     <= '0;
                        saddr_q <= addr_bit(4'd0, chan_q);
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_d;
                    if (cnt_last) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            if (k_q >= 4'd4) shreg_q <= {shreg_q[10:0], ADC_SDAT};
                        end else if (k_q == 4'd15) begin
                            state_q <= DONE;
                            cs_n_q  <= 1'b1;
                            valid_q <= 1'b1;
                            data_q  <= shreg_q;
                            schan_q <= chan_q;
                        end else begin
                            sclk_q  <= 1'b0;
                            k_q     <= k_q + 4'd1;
                            saddr_q <= addr_bit(k_q + 4'd1, chan_q);
                        end
                    end
                end
                DONE: state_q <= HOLD;
                HOLD: begin
                    cnt_q <= cnt_d;
                    if (cnt_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign sample_chan  = schan_q;
    assign ADC_CS_N     = cs_n_q;
    assign ADC_SCLK     = sclk_q;
    assign ADC_SADDR    = saddr_q;
endmodule

// File: doc/adc_spi_master.md
ADC_SPI_MASTER -- requirements
Module: adc_spi_master

Interface
REQ-001 SHALL have parameter HALF_DIV, default 25: CLK50MHZ cycles per ADC_SCLK half-period (1 MHz SCLK); legal range 2..255.
REQ-002 SHALL have port CLK50MHZ, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: conversion request, sampled only when busy=0.
REQ-005 SHALL have port chan, input, 3: ADC channel for the requested conversion.
REQ-006 SHALL have port busy, output, 1: a frame is in progress.
REQ-007 SHALL have port sample_valid, output, 1: one-cycle pulse marking new sample_data and sample_chan.
REQ-008 SHALL have port sample_data, output, 12: last converted result, MSB first as received.
REQ-009 SHALL have port sample_chan, output, 3: channel of the last converted result.
REQ-010 SHALL have port ADC_CS_N, output, 1: ADC chip select, active low.
REQ-011 SHALL have port ADC_SCLK, output, 1: ADC serial clock, idles high.
REQ-012 SHALL have port ADC_SADDR, output, 1: ADC serial address/control input (DIN).
REQ-013 SHALL have port ADC_SDAT, input, 1: ADC serial data out (DOUT).

Function
REQ-014 SHALL implement the FSM IDLE -> SETUP -> SHIFT -> DONE -> HOLD -> IDLE.
REQ-015 SHALL accept start only in IDLE; at acceptance cycle T it SHALL latch chan, set busy=1 and ADC_CS_N=0 from cycle T+1.
REQ-016 SHALL ignore start while busy=1, with no queuing and no effect on the current frame.
REQ-017 SHALL hold SETUP for HALF_DIV cycles with ADC_SCLK=1 and ADC_CS_N=0.
REQ-018 SHALL run SHIFT as 16 SCLK periods, bit index k=0..15; each period is HALF_DIV cycles low, then HALF_DIV cycles high.
REQ-019 SHALL update ADC_SADDR only on SCLK falling edges: latched chan[2] for k=2, chan[1] for k=3, chan[0] for k=4, and 0 for all other k.
REQ-020 SHALL sample ADC_SDAT in the same cycle ADC_SCLK goes 0->1; samples for k=4..15 SHALL shift into a 12-bit register as D11..D0, and samples for k=0..3 SHALL be discarded.
REQ-021 SHALL enter DONE after the last high phase: ADC_CS_N=1, ADC_SCLK=1, sample_valid=1 for exactly one cycle, sample_data and sample_chan loaded in that same cycle.
REQ-022 SHALL hold HOLD for HALF_DIV cycles (CS_N high, quiet time), then enter IDLE with busy=0.
REQ-023 SHALL meet these latencies: sample_valid at T+33*HALF_DIV+1; busy=0 from T+34*HALF_DIV+2; with default HALF_DIV=25, valid at T+826 and idle at T+852.
REQ-024 SHALL keep sample_data and sample_chan stable between sample_valid pulses.
REQ-025 SHALL let start asserted in the first IDLE cycle after HOLD begin a new frame; back-to-back frame period is 34*HALF_DIV+2 cycles.
REQ-026 SHALL implement the SCLK divider counter as an 8-bit counter that wraps to 0 at HALF_DIV-1 and never free-runs outside SETUP, SHIFT and HOLD.

Reset
REQ-027 SHALL, while reset_n=0 at a clock edge, force: state=IDLE, busy=0, sample_valid=0, sample_data=0, sample_chan=0, ADC_CS_N=1, ADC_SCLK=1, ADC_SADDR=0, and all counters 0.
REQ-028 SHALL abort a frame on reset mid-frame, with CS_N=1 on the next edge, no sample_valid pulse, and no partial result visible.
REQ-029 SHALL not begin a frame in the cycle reset_n deasserts; start is first acceptable in the following cycle.

Verification
REQ-030 SHALL cover: HALF_DIV=25, chan=3'b101, ADC model returns 12'hA5C -> ADC_SADDR pattern 0,0,1,0,1,0.. over k=0..5; sample_valid at T+826; sample_data=12'hA5C; sample_chan=5.
REQ-031 SHALL cover: HALF_DIV=2, 20 back-to-back frames with random chan and data -> each result matches; CS_N high for at least 2 cycles between frames; frame period 70 cycles.
REQ-032 SHALL cover: start pulsed with chan=7 mid-frame of a chan=1 frame -> frame completes with sample_chan=1; no second frame starts.
REQ-033 SHALL cover: reset_n low at k=9 -> next edge CS_N=1, SCLK=1, busy=0; no sample_valid; sample_data=0.
REQ-034 SHALL cover: ADC_SDAT held 1 for k=0..3 and 0 for k=4..15 -> sample_data=12'h000 (leading bits discarded).
REQ-035 SHALL cover: SCLK checker -> exactly 16 rising edges per CS_N low window; every high/low phase is HALF_DIV cycles; ADC_SADDR never changes while SCLK is high.
